dmem_responder: RTL and testbench

- Memory-side responder for the single-cycle core's data port. It receives address, write enable and write data from the core, and returns read data to the core in the same cycle.
- Backs a word-addressed data RAM and a small MMIO page. The MMIO page holds a transmit FIFO (drained by an external valid/ready consumer), a status register, a free-running cycle counter and sticky error flags.
- Sits beside the core at SoC top level, wired directly to dmem_wren / ALU_result / dmem_data_in / dmem_data_out.

---
 rtl/dmem_responder_if.sv | 21 ++
 rtl/dmem_responder.sv | 113 +++++++++++
 tb/tb_dmem_responder.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - core data-port and TX byte-stream bundle for dmem_responder
interface dmem_responder_if;
  logic        dmem_wren;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_data_in;
  logic [31:0] dmem_data_out;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  // master: the core plus the downstream byte consumer
  modport master (
    output dmem_wren, dmem_addr, dmem_data_in, tx_ready,
    input  dmem_data_out, tx_data, tx_valid
  );

  modport slave (
    input  dmem_wren, dmem_addr, dmem_data_in, tx_ready,
    output dmem_data_out, tx_data, tx_valid
  );
endinterface

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data RAM plus MMIO page (TX FIFO, status, cycle counter)
module dmem_responder #(
  parameter int          RAM_WORDS  = 256,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000
) (
  input logic             clk,
  input logic             reset,
  dmem_responder_if.slave bus
);
  localparam int AW = $clog2(RAM_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   ram [RAM_WORDS];
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [31:0]   cycle;
  logic          overflow;
  logic          unmapped;

  logic          ram_hit;
  logic          mmio_hit;
  logic [1:0]    reg_sel;
  logic [AW-1:0] ram_idx;
  logic          full;
  logic          empty;
  logic          push_req;
  logic          push_ok;
  logic          pop;
  logic          status_wr;
  logic          cycle_wr;
  logic          overflow_set;
  logic [31:0]   status_word;
  logic [31:0]   rdata;
  logic [1:0]    unused_addr_lsbs;

  assign ram_hit  = (bus.dmem_addr[31:AW+2] == '0);
  assign mmio_hit = (bus.dmem_addr[31:4] == MMIO_BASE[31:4]);
  assign reg_sel  = bus.dmem_addr[3:2];
  assign ram_idx  = bus.dmem_addr[AW+1:2];
  assign unused_addr_lsbs = bus.dmem_addr[1:0];

  assign full  = (count == CW'(FIFO_DEPTH));
  assign empty = (count == '0);
  assign pop   = bus.tx_valid && bus.tx_ready;

  assign push_req  = bus.dmem_wren && mmio_hit && (reg_sel == 2'd0);
  assign status_wr = bus.dmem_wren && mmio_hit && (reg_sel == 2'd1);
  assign cycle_wr  = bus.dmem_wren && mmio_hit && (reg_sel == 2'd2);

  // A push into a full FIFO is still accepted when a pop frees a slot on the same edge.
  assign push_ok      = push_req && (!full || pop);
  assign overflow_set = push_req && full && !pop;

  assign status_word = {16'h0, 8'(count), 4'h0, unmapped, overflow, empty, full};

  always_comb begin
    rdata = '0;
    if (ram_hit) begin
      rdata = ram[ram_idx];
    end else if (mmio_hit) begin
      case (reg_sel)
        2'd1:    rdata = status_word;
        2'd2:    rdata = cycle;
        default: rdata = '0;
      endcase
    end
  end

  assign bus.dmem_data_out = rdata;
  assign bus.tx_data       = fifo_mem[rd_ptr];
  assign bus.tx_valid      = !empty;

  always_ff @(posedge clk) begin
    if (!reset && bus.dmem_wren && ram_hit) begin
      ram[ram_idx] <= bus.dmem_data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push_ok) begin
      fifo_mem[wr_ptr] <= bus.dmem_data_in[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      cycle    <= '0;
      overflow <= 1'b0;
      unmapped <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop)      count <= count + 1'b1;
      else if (!push_ok && pop) count <= count - 1'b1;

      cycle <= cycle_wr ? bus.dmem_data_in : cycle + 32'd1;

      // Software clears win over a same-edge set.
      if (status_wr && bus.dmem_data_in[2]) overflow <= 1'b0;
      else if (overflow_set)                overflow <= 1'b1;

      if (status_wr && bus.dmem_data_in[3]) unmapped <= 1'b0;
      else if (!ram_hit && !mmio_hit)       unmapped <= 1'b1;
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed bench for dmem_responder
module tb_dmem_responder;
  localparam logic [31:0] A_TXDATA = 32'hFFFF_0000;
  localparam logic [31:0] A_STATUS = 32'hFFFF_0004;
  localparam logic [31:0] A_CYCLE  = 32'hFFFF_0008;

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;

  dmem_responder_if bus ();

  dmem_responder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.dmem_wren    = 1'b0;
    bus.dmem_addr    = 32'h0;
    bus.dmem_data_in = 32'h0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.dmem_wren    = 1'b1;
    bus.dmem_addr    = a;
    bus.dmem_data_in = d;
    tick();
    idle();
  endtask

  task automatic rd(input logic [31:0] a);
    bus.dmem_wren = 1'b0;
    bus.dmem_addr = a;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.tx_ready = 1'b0;
    idle();
    tick();
    tick();
    reset = 1'b0;
    rd(A_STATUS);
    n_vec++;
    if (bus.dmem_data_out !== 32'h0000_0002) begin
      n_err++;
      $display("FAIL reset_status: got %h expected %h", bus.dmem_data_out, 32'h0000_0002);
    end
    n_vec++;
    if (bus.tx_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_tx_valid: got %b expected 0", bus.tx_valid);
    end
    rd(A_CYCLE);
    n_vec++;
    if (bus.dmem_data_out !== 32'h0) begin
      n_err++;
      $display("FAIL reset_cycle0: got %h expected 0", bus.dmem_data_out);
    end
    tick();
    rd(A_CYCLE);
    n_vec++;
    if (bus.dmem_data_out !== 32'h1) begin
      n_err++;
      $display("FAIL reset_cycle1: got %h expected 1", bus.dmem_data_out);
    end
    idle();
  endtask

  task automatic test_ram();
    wr(32'h10, 32'hCAFE_F00D);
    rd(32'h10);
    n_vec++;
    if (bus.dmem_data_out !== 32'hCAFE_F00D) begin
      n_err++;
      $display("FAIL ram_rd_10: got %h expected %h", bus.dmem_data_out, 32'hCAFE_F00D);
    end
    rd(32'h13);
    n_vec++;
    if (bus.dmem_data_out !== 32'hCAFE_F00D) begin
      n_err++;
      $display("FAIL ram_rd_13: got %h expected %h", bus.dmem_data_out, 32'hCAFE_F00D);
    end
    wr(32'h3FC, 32'h1234_5678);
    rd(32'h3FC);
    n_vec++;
    if (bus.dmem_data_out !== 32'h1234_5678) begin
      n_err++;
      $display("FAIL ram_last_word: got %h expected %h", bus.dmem_data_out, 32'h1234_5678);
    end
    rd(32'h10);
    n_vec++;
    if (bus.dmem_data_out !== 32'hCAFE_F00D) begin
      n_err++;
      $display("FAIL ram_no_alias: got %h expected %h", bus.dmem_data_out, 32'hCAFE_F00D);
    end
    idle();
  endtask

  task automatic test_fifo_fill();
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) wr(A_TXDATA, 32'h41 + i);
    rd(A_STATUS);
    n_vec++;
    if (bus.dmem_data_out !== 32'h0000_0801) begin
      n_err++;
      $display("FAIL fill_status: got %h expected %h", bus.dmem_data_out, 32'h0000_0801);
    end
    wr(A_TXDATA, 32'h49);
    rd(A_STATUS);
    n_vec++;
    if (bus.dmem_data_out !== 32'h0000_0805) begin
      n_err++;
      $display("FAIL overflow_status: got %h expected %h", bus.dmem_data_out, 32'h0000_0805);
    end
    n_vec++;
    if (bus.tx_data !== 8'h41 || bus.tx_valid !== 1'b1) begin
      n_err++;
      $display("FAIL overflow_head: got %h/%b expected 41/1", bus.tx_data, bus.tx_valid);
    end
    idle();
  endtask

  task automatic test_drain();
    idle();
    bus.tx_ready = 1'b1;
    #1;
    for (int i = 0; i < 8; i++) begin
      n_vec++;
      if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'(8'h41 + i)) begin
        n_err++;
        $display("FAIL drain_%0d: got %h/%b expected %h/1", i, bus.tx_data, bus.tx_valid, 8'(8'h41 + i));
      end
      tick();
    end
    n_vec++;
    if (bus.tx_valid !== 1'b0) begin
      n_err++;
      $display("FAIL drain_empty: got %b expected 0", bus.tx_valid);
    end
    bus.tx_ready = 1'b0;
    wr(A_STATUS, 32'h4);
    rd(A_STATUS);
    n_vec++;
    if (bus.dmem_data_out !== 32'h0000_0002) begin
      n_err++;
      $display("FAIL overflow_clear: got %h expected %h", bus.dmem_data_out, 32'h0000_0002);
    end
    idle();
  endtask

  task automatic test_full_push_pop();
    logic [7:0] exp_q [$];
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wr(A_TXDATA, 32'h61 + i);
      exp_q.push_back(8'(8'h61 + i));
    end
    bus.tx_ready = 1'b1;
    wr(A_TXDATA, 32'h55);
    bus.tx_ready = 1'b0;
    void'(exp_q.pop_front());
    exp_q.push_back(8'h55);
    rd(A_STATUS);
    n_vec++;
    if (bus.dmem_data_out !== 32'h0000_0801) begin
      n_err++;
      $display("FAIL pushpop_status: got %h expected %h", bus.dmem_data_out, 32'h0000_0801);
    end
    idle();
    bus.tx_ready = 1'b1;
    #1;
    for (int i = 0; i < 8; i++) begin
      n_vec++;
      if (bus.tx_valid !== 1'b1 || bus.tx_data !== exp_q[i]) begin
        n_err++;
        $display("FAIL pushpop_drain_%0d: got %h/%b expected %h/1", i, bus.tx_data, bus.tx_valid, exp_q[i]);
      end
      tick();
    end
    n_vec++;
    if (bus.tx_valid !== 1'b0) begin
      n_err++;
      $display("FAIL pushpop_empty: got %b expected 0", bus.tx_valid);
    end
    bus.tx_ready = 1'b0;
  endtask

  task automatic test_unmapped();
    rd(32'h8000_0000);
    n_vec++;
    if (bus.dmem_data_out !== 32'h0) begin
      n_err++;
      $display("FAIL unmapped_read: got %h expected 0", bus.dmem_data_out);
    end
    wr(32'h8000_0000, 32'hDEAD_BEEF);
    rd(A_STATUS);
    n_vec++;
    if (bus.dmem_data_out !== 32'h0000_000A) begin
      n_err++;
      $display("FAIL unmapped_sticky: got %h expected %h", bus.dmem_data_out, 32'h0000_000A);
    end
    rd(32'h0);
    n_vec++;
    if (bus.dmem_data_out === 32'hDEAD_BEEF) begin
      n_err++;
      $display("FAIL unmapped_write_leak: got %h expected not DEADBEEF", bus.dmem_data_out);
    end
    wr(A_STATUS, 32'h8);
    rd(A_STATUS);
    n_vec++;
    if (bus.dmem_data_out !== 32'h0000_0002) begin
      n_err++;
      $display("FAIL unmapped_clear: got %h expected %h", bus.dmem_data_out, 32'h0000_0002);
    end
    idle();
  endtask

  task automatic test_reset_push();
    bus.tx_ready = 1'b0;
    wr(A_TXDATA, 32'h11);
    reset = 1'b1;
    wr(A_TXDATA, 32'h77);
    reset = 1'b0;
    rd(A_STATUS);
    n_vec++;
    if (bus.dmem_data_out !== 32'h0000_0002) begin
      n_err++;
      $display("FAIL reset_push_status: got %h expected %h", bus.dmem_data_out, 32'h0000_0002);
    end
    n_vec++;
    if (bus.tx_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_push_valid: got %b expected 0", bus.tx_valid);
    end
    rd(32'h10);
    n_vec++;
    if (bus.dmem_data_out !== 32'hCAFE_F00D) begin
      n_err++;
      $display("FAIL reset_ram_kept: got %h expected %h", bus.dmem_data_out, 32'hCAFE_F00D);
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_ram();
    test_fifo_fill();
    test_drain();
    test_full_push_pop();
    test_unmapped();
    test_reset_push();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
